// File: rtl/flash_boot_loader.sv
// -----------------------------------------------------------------------------
// flash_boot_loader
//
// Boot-time image copier. After reset it walks flash ROM addresses
// 0..COPY_LENGTH-1 over the combinational ROM port and streams each word into
// system memory through a valid/ready write port. The core is held in reset
// (CoreReset=1) until the last word has been accepted. A Start pulse while
// DONE re-runs the whole copy.
//
// Optional feature macro: FLASH_BOOT_CHECKSUM_EN
//   defined   -> Checksum accumulates every accepted write word, modulo 2^16
//   undefined -> Checksum is tied to zero and no adder is built
//
// Parameters:
//   COPY_LENGTH  number of 16-bit words copied (1..1024)
//   DEST_BASE    memory word address that receives ROM word 0
//
// Ports:
//   clk              system clock, rising edge
//   async_rst_n      asynchronous active-low reset
//   Start            single-cycle re-copy request, honoured only in DONE
//   RomAddress       flash ROM address (current word index)
//   RomValue         ROM data, combinational from RomAddress
//   MemWriteValid    write request
//   MemWriteReady    write accepted when high together with MemWriteValid
//   MemWriteAddress  destination word address
//   MemWriteData     destination data
//   Busy             copy in progress (FETCH / WRITE)
//   Done             image fully written
//   CoreReset        holds the core in reset in every state except DONE
//   Checksum         running image checksum (see macro above)
// -----------------------------------------------------------------------------
module flash_boot_loader #(
  parameter int unsigned COPY_LENGTH = 1024,
  parameter logic [15:0] DEST_BASE   = 16'h0000
) (
  input  logic        clk,
  input  logic        async_rst_n,
  input  logic        Start,
  output logic [9:0]  RomAddress,
  input  logic [15:0] RomValue,
  output logic        MemWriteValid,
  input  logic        MemWriteReady,
  output logic [15:0] MemWriteAddress,
  output logic [15:0] MemWriteData,
  output logic        Busy,
  output logic        Done,
  output logic        CoreReset,
  output logic [15:0] Checksum
);

  localparam logic [9:0] LAST_INDEX = 10'(COPY_LENGTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  index_q, index_d;
  logic        wr_valid_q, wr_valid_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        core_rst_q, core_rst_d;
  logic        accept_s;

  // A write completes only while a request is actually outstanding.
  assign accept_s = wr_valid_q & MemWriteReady;

  // State register.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (accept_s) begin
          if (index_q == LAST_INDEX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        if (Start) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs, decoded from the next state so they register in step
  // with the state change.
  always_comb begin
    busy_d     = 1'b0;
    done_d     = 1'b0;
    core_rst_d = 1'b1;
    case (state_d)
      ST_IDLE: begin
        busy_d     = 1'b0;
        done_d     = 1'b0;
        core_rst_d = 1'b1;
      end
      ST_FETCH, ST_WRITE: begin
        busy_d     = 1'b1;
        done_d     = 1'b0;
        core_rst_d = 1'b1;
      end
      ST_DONE: begin
        busy_d     = 1'b0;
        done_d     = 1'b1;
        core_rst_d = 1'b0;
      end
      default: begin
        busy_d     = 1'b0;
        done_d     = 1'b0;
        core_rst_d = 1'b1;
      end
    endcase
  end

  // Index and write-port datapath.
  always_comb begin
    index_d    = index_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        index_d = 10'd0;
      end
      ST_FETCH: begin
        // ROM is zero-latency: RomValue already reflects RomAddress=index_q.
        wr_data_d  = RomValue;
        wr_addr_d  = DEST_BASE + {6'd0, index_q};
        wr_valid_d = 1'b1;
      end
      ST_WRITE: begin
        if (accept_s) begin
          wr_valid_d = 1'b0;
          // Hold the index on the last word so RomAddress never passes it.
          if (index_q != LAST_INDEX) begin
            index_d = index_q + 10'd1;
          end else begin
            index_d = index_q;
          end
        end else begin
          wr_valid_d = wr_valid_q;
        end
      end
      ST_DONE: begin
        if (Start) begin
          index_d = 10'd0;
        end else begin
          index_d = index_q;
        end
      end
      default: begin
        index_d    = 10'd0;
        wr_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      index_q    <= 10'd0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= 16'h0000;
      wr_data_q  <= 16'h0000;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      index_q    <= index_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
    end
  end

`ifdef FLASH_BOOT_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  // Checksum accumulates accepted words; cleared when a re-copy starts.
  always_comb begin
    checksum_d = checksum_q;
    if (state_q == ST_WRITE && accept_s) begin
      checksum_d = checksum_q + wr_data_q;
    end else if (state_q == ST_DONE && Start) begin
      checksum_d = 16'h0000;
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      checksum_q <= 16'h0000;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign Checksum = checksum_q;
`else
  assign Checksum = 16'h0000;
`endif

  assign RomAddress      = index_q;
  assign MemWriteValid   = wr_valid_q;
  assign MemWriteAddress = wr_addr_q;
  assign MemWriteData    = wr_data_q;
  assign Busy            = busy_q;
  assign Done            = done_q;
  assign CoreReset       = core_rst_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_flash_boot_loader
//
// Directed bench for flash_boot_loader. Three instances share the clock:
//   a: COPY_LENGTH=4, DEST_BASE=0100, ROM = {6'b0,addr}^A5A5 (main scenarios)
//   b: COPY_LENGTH=4, DEST_BASE=FFFE, same ROM (address wrap)
//   c: COPY_LENGTH=4, DEST_BASE=0000, ROM words 0001,0002,0003,FFFF (checksum)
// -----------------------------------------------------------------------------
module tb_flash_boot_loader;

  logic clk;
  logic rst_a_n, rst_bc_n;

  logic        a_start, a_valid, a_ready, a_busy, a_done, a_core_rst;
  logic [9:0]  a_rom_addr;
  logic [15:0] a_rom_val, a_wr_addr, a_wr_data, a_csum;

  logic        b_valid, b_busy, b_done, b_core_rst;
  logic [9:0]  b_rom_addr;
  logic [15:0] b_rom_val, b_wr_addr, b_wr_data, b_csum;

  logic        c_valid, c_busy, c_done, c_core_rst;
  logic [9:0]  c_rom_addr;
  logic [15:0] c_rom_val, c_wr_addr, c_wr_data, c_csum;

  int n_cmp;
  int n_err;
  int edge_n;

  logic [15:0] a_log_addr[$];
  logic [15:0] a_log_data[$];
  logic [15:0] b_log_addr[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign a_rom_val = {6'd0, a_rom_addr} ^ 16'hA5A5;
  assign b_rom_val = {6'd0, b_rom_addr} ^ 16'hA5A5;

  always_comb begin
    case (c_rom_addr)
      10'd0:   c_rom_val = 16'h0001;
      10'd1:   c_rom_val = 16'h0002;
      10'd2:   c_rom_val = 16'h0003;
      10'd3:   c_rom_val = 16'hFFFF;
      default: c_rom_val = 16'h0000;
    endcase
  end

  flash_boot_loader #(.COPY_LENGTH(4), .DEST_BASE(16'h0100)) u_a (
    .clk(clk), .async_rst_n(rst_a_n), .Start(a_start),
    .RomAddress(a_rom_addr), .RomValue(a_rom_val),
    .MemWriteValid(a_valid), .MemWriteReady(a_ready),
    .MemWriteAddress(a_wr_addr), .MemWriteData(a_wr_data),
    .Busy(a_busy), .Done(a_done), .CoreReset(a_core_rst), .Checksum(a_csum)
  );

  flash_boot_loader #(.COPY_LENGTH(4), .DEST_BASE(16'hFFFE)) u_b (
    .clk(clk), .async_rst_n(rst_bc_n), .Start(1'b0),
    .RomAddress(b_rom_addr), .RomValue(b_rom_val),
    .MemWriteValid(b_valid), .MemWriteReady(1'b1),
    .MemWriteAddress(b_wr_addr), .MemWriteData(b_wr_data),
    .Busy(b_busy), .Done(b_done), .CoreReset(b_core_rst), .Checksum(b_csum)
  );

  flash_boot_loader #(.COPY_LENGTH(4), .DEST_BASE(16'h0000)) u_c (
    .clk(clk), .async_rst_n(rst_bc_n), .Start(1'b0),
    .RomAddress(c_rom_addr), .RomValue(c_rom_val),
    .MemWriteValid(c_valid), .MemWriteReady(1'b1),
    .MemWriteAddress(c_wr_addr), .MemWriteData(c_wr_data),
    .Busy(c_busy), .Done(c_done), .CoreReset(c_core_rst), .Checksum(c_csum)
  );

  // Log every handshake that will complete on the coming rising edge.
  always @(negedge clk) begin
    if (a_valid && a_ready) begin
      a_log_addr.push_back(a_wr_addr);
      a_log_data.push_back(a_wr_data);
    end
    if (b_valid) begin
      b_log_addr.push_back(b_wr_addr);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, ".rom_addr"}, 32'(a_rom_addr), 32'd0);
    check_val({tag, ".valid"},    32'(a_valid),    32'd0);
    check_val({tag, ".wr_addr"},  32'(a_wr_addr),  32'd0);
    check_val({tag, ".wr_data"},  32'(a_wr_data),  32'd0);
    check_val({tag, ".busy"},     32'(a_busy),     32'd0);
    check_val({tag, ".done"},     32'(a_done),     32'd0);
    check_val({tag, ".core_rst"}, 32'(a_core_rst), 32'd1);
    check_val({tag, ".csum"},     32'(a_csum),     32'd0);
  endtask

  // Tick until Done; Ready is low on edges stall_lo..stall_hi, Start is
  // pulsed for the edge numbered start_at. Returns -1 if Done never rises.
  task automatic run_copy(input int stall_lo, input int stall_hi,
                          input int start_at, output int done_edge);
    done_edge = -1;
    for (int k = 0; k < 40; k++) begin
      a_ready = !((edge_n + 1) >= stall_lo && (edge_n + 1) <= stall_hi);
      a_start = ((edge_n + 1) == start_at);
      tick();
      a_start = 1'b0;
      if (edge_n >= stall_lo && edge_n <= stall_hi) begin
        check_val($sformatf("stall%0d.valid", edge_n), 32'(a_valid),   32'd1);
        check_val($sformatf("stall%0d.addr",  edge_n), 32'(a_wr_addr), 32'h0101);
        check_val($sformatf("stall%0d.data",  edge_n), 32'(a_wr_data), 32'hA5A4);
      end
      if (a_done) begin
        done_edge = edge_n;
        break;
      end
    end
    a_ready = 1'b1;
    check_val("core_rst_at_done", 32'(a_core_rst), 32'd0);
    check_val("busy_at_done",     32'(a_busy),     32'd0);
  endtask

  task automatic check_writes(input string tag);
    logic [15:0] exp_d;
    check_val({tag, ".count"}, 32'(a_log_addr.size()), 32'd4);
    for (int i = 0; i < 4 && i < a_log_addr.size(); i++) begin
      exp_d = 16'(i) ^ 16'hA5A5;
      check_val($sformatf("%s.addr%0d", tag, i), 32'(a_log_addr[i]), 32'h0100 + 32'(i));
      check_val($sformatf("%s.data%0d", tag, i), 32'(a_log_data[i]), 32'(exp_d));
    end
  endtask

  initial begin
    int de;
    n_cmp    = 0;
    n_err    = 0;
    rst_a_n  = 1'b1;
    rst_bc_n = 1'b1;
    a_start  = 1'b0;
    a_ready  = 1'b1;
    #2;
    rst_a_n  = 1'b0;
    rst_bc_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");

    // Test 1: plain copy with a Start pulse during Busy (ignored).
    @(negedge clk);
    a_log_addr.delete();
    a_log_data.delete();
    b_log_addr.delete();
    rst_a_n  = 1'b1;
    rst_bc_n = 1'b1;
    edge_n = -1;
    tick();
    check_val("e0.busy",     32'(a_busy),     32'd1);
    check_val("e0.rom_addr", 32'(a_rom_addr), 32'd0);
    check_val("e0.valid",    32'(a_valid),    32'd0);
    tick();
    check_val("e1.valid",    32'(a_valid),    32'd1);
    check_val("e1.addr",     32'(a_wr_addr),  32'h0100);
    check_val("e1.data",     32'(a_wr_data),  32'hA5A5);
    run_copy(99, 99, 2, de);
    check_val("t1.done_edge", 32'(de), 32'd8);
    check_writes("t1");
    check_val("t1.csum_a", 32'(a_csum), 32'd0);

    // Instances b and c were released together with a and are finished.
    check_val("b.done", 32'(b_done), 32'd1);
    check_val("b.count", 32'(b_log_addr.size()), 32'd4);
    if (b_log_addr.size() == 4) begin
      check_val("b.addr0", 32'(b_log_addr[0]), 32'hFFFE);
      check_val("b.addr1", 32'(b_log_addr[1]), 32'hFFFF);
      check_val("b.addr2", 32'(b_log_addr[2]), 32'h0000);
      check_val("b.addr3", 32'(b_log_addr[3]), 32'h0001);
    end
    check_val("c.done", 32'(c_done), 32'd1);
`ifdef FLASH_BOOT_CHECKSUM_EN
    check_val("c.csum", 32'(c_csum), 32'h0005);
`else
    check_val("c.csum", 32'(c_csum), 32'h0000);
`endif

    // Test 2: Start in DONE, then 3 cycles of backpressure on word 1.
    repeat (2) tick();
    a_log_addr.delete();
    a_log_data.delete();
    edge_n  = -1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check_val("t2.e0.core_rst", 32'(a_core_rst), 32'd1);
    check_val("t2.e0.done",     32'(a_done),     32'd0);
    check_val("t2.e0.busy",     32'(a_busy),     32'd1);
    run_copy(4, 6, -1, de);
    check_val("t2.done_edge", 32'(de), 32'd11);
    check_writes("t2");

    // Test 3: reset while word 2 sits in WRITE, then automatic restart.
    repeat (2) tick();
    edge_n  = -1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    while (edge_n < 5) tick();
    check_val("t3.pre.valid", 32'(a_valid),   32'd1);
    check_val("t3.pre.addr",  32'(a_wr_addr), 32'h0102);
    rst_a_n = 1'b0;
    #1;
    check_reset_values("t3.rst");
    @(negedge clk);
    a_log_addr.delete();
    a_log_data.delete();
    rst_a_n = 1'b1;
    edge_n  = -1;
    run_copy(99, 99, -1, de);
    check_val("t3.done_edge", 32'(de), 32'd8);
    check_writes("t3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flash_boot_loader.md
# flash_boot_loader

Boot-time image copier that sits on the read side of the flash ROM data block. After reset it sweeps ROM addresses 0 to COPY_LENGTH-1 over the combinational ROM port and streams each word into system memory through a valid/ready write port. It holds the core in reset until the last word has been accepted. It sits between the flash ROM and the memory write arbiter in the system-control group.

## Interface
- COPY_LENGTH, 1024: number of 16-bit words copied; legal range 1..1024.
- DEST_BASE, 16'h0000: memory word address that receives ROM word 0.
- clk  in  1  system clock; all state updates on the rising edge.
- async_rst_n  in  1  reset, asynchronous, active-low.
- Start  in  1  single-cycle request to re-copy; honoured only in DONE.
- RomAddress  out  10  address to the flash ROM.
- RomValue  in  16  ROM data, combinational from RomAddress in the same cycle.
- MemWriteValid  out  1  write request.
- MemWriteReady  in  1  write accepted when high together with MemWriteValid on a rising edge.
- MemWriteAddress  out  16  destination word address.
- MemWriteData  out  16  destination data.
- Busy  out  1  copy in progress.
- Done  out  1  image fully written.
- CoreReset  out  1  high holds the core in reset.
- Checksum  out  16  running image checksum; see Configuration.

## Operation
- States: IDLE, FETCH, WRITE, DONE. The reset state is IDLE.
- IDLE: unconditionally moves to FETCH on the first rising edge after reset deassertion (auto-boot). Word index is 0.
- FETCH: RomAddress = index. On the edge:
  - latch RomValue into MemWriteData;
  - load MemWriteAddress = DEST_BASE + index, modulo 2^16;
  - set MemWriteValid;
  - go to WRITE.
- WRITE: hold MemWriteValid, MemWriteAddress and MemWriteData stable until MemWriteValid && MemWriteReady on an edge. On that edge, clear MemWriteValid, then:
  - if index == COPY_LENGTH-1, go to DONE;
  - otherwise increment index and go to FETCH.
- DONE:
  - Done=1, CoreReset=0, Busy=0.
  - Start=1 clears Done, sets CoreReset=1, resets index to 0, clears Checksum and goes to FETCH.
- Start in IDLE, FETCH or WRITE is ignored and not queued.
- MemWriteReady while MemWriteValid=0 is ignored.
- Busy=1 in FETCH and WRITE only.
- CoreReset=1 in every state except DONE.
- The index never wraps. RomAddress never exceeds COPY_LENGTH-1.

## Timing
- Reset values:
  - RomAddress=0, MemWriteValid=0, MemWriteAddress=0, MemWriteData=0;
  - Busy=0, Done=0, CoreReset=1, Checksum=0.
- Reset assertion takes effect immediately, including mid-copy. All outputs return to reset values. A partially written image is simply overwritten on the automatic restart.
- Number edges from 0, where edge 0 is the first rising edge after reset deassertion. With MemWriteReady held high:
  - edge 0: IDLE to FETCH;
  - word i is latched at edge 2i+1 and accepted at edge 2i+2;
  - Done rises, and CoreReset falls, at edge 2*COPY_LENGTH.
- Each cycle of MemWriteReady=0 in WRITE adds exactly one cycle. No word is duplicated or skipped.
- ROM read latency is zero. Data is sampled at the end of the single FETCH cycle.

## Configuration
- FLASH_BOOT_CHECKSUM_EN defined:
  - Checksum adds MemWriteData on each accepted write, modulo 2^16.
  - It clears on reset and on Start in DONE.
  - It is final and stable while Done=1.
- FLASH_BOOT_CHECKSUM_EN undefined: Checksum is tied to 16'h0000 and no adder is built.

## Test plan
- COPY_LENGTH=4, DEST_BASE=16'h0100, ROM model returns {6'b0,addr}^16'hA5A5, Ready=1:
  - writes (0100,A5A5), (0101,A5A4), (0102,A5A7), (0103,A5A6);
  - Done=1 and CoreReset=0 at edge 8.
- Backpressure: Ready low for 3 cycles during word 1:
  - Valid, address and data held stable throughout;
  - exactly 4 accepted writes;
  - Done at edge 11.
- Reset pulsed while word 2 is in WRITE: all outputs take reset values, and the copy restarts from RomAddress=0 with Done at edge 8 after release.
- Start pulsed during Busy: ignored. Start pulsed in DONE: CoreReset=1 and Done=0 on the next edge, and the full 4-word copy repeats.
- DEST_BASE=16'hFFFE, COPY_LENGTH=4: write addresses are FFFE, FFFF, 0000, 0001.
- FLASH_BOOT_CHECKSUM_EN defined, ROM words 0001, 0002, 0003, FFFF: Checksum=16'h0005 at Done. Undefined: Checksum stays 0000.
